// File: rtl/machine_timer_pkg.sv
// ----------------------------------------------------------------------------
// machine_timer_pkg : register map, CTRL field layout and bus FSM encoding
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef MACHINE_TIMER_DEFINES_SVH
`define MACHINE_TIMER_DEFINES_SVH
`define size_X_LEN      32
`define TMR_MTIME_LO    5'h00
`define TMR_MTIME_HI    5'h04
`define TMR_CMP_LO      5'h08
`define TMR_CMP_HI      5'h0C
`define TMR_CTRL        5'h10
`define TMR_CTRL_EN_BIT 0
`endif

package machine_timer_pkg;

  localparam int XLEN         = `size_X_LEN;
  localparam int ADDR_W       = 5;
  localparam int CTRL_EN_BIT  = `TMR_CTRL_EN_BIT;
  localparam int CTRL_DIV_LSB = 8;

  localparam logic [0:0] BUS_IDLE = 1'b0;
  localparam logic [0:0] BUS_RESP = 1'b1;

  typedef enum logic [2:0] {
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_CTRL,
    REG_NONE
  } reg_sel_e;

  // Misaligned offsets never match an entry, so they decode as unmapped.
  function automatic reg_sel_e decode_addr(input logic [ADDR_W-1:0] addr);
    reg_sel_e sel;
    case (addr)
      `TMR_MTIME_LO: sel = REG_MTIME_LO;
      `TMR_MTIME_HI: sel = REG_MTIME_HI;
      `TMR_CMP_LO:   sel = REG_CMP_LO;
      `TMR_CMP_HI:   sel = REG_CMP_HI;
      `TMR_CTRL:     sel = REG_CTRL;
      default:       sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/machine_timer_if.sv
// ----------------------------------------------------------------------------
// machine_timer_if : single-outstanding req/ack register port of the timer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface machine_timer_if;

  logic                                bus_req;
  logic                                bus_we;
  logic [machine_timer_pkg::ADDR_W-1:0] bus_addr;
  logic [machine_timer_pkg::XLEN-1:0]   bus_wdata;
  logic [machine_timer_pkg::XLEN-1:0]   bus_rdata;
  logic                                bus_ack;
  logic                                bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack, bus_err
  );

endinterface

`default_nettype wire

// File: rtl/machine_timer_prescaler.sv
// ----------------------------------------------------------------------------
// timer_prescaler : divide-by-(div+1) tick generator that holds phase while gated
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  gate,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  clear,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count_q;
  logic [PRESCALE_W-1:0] count_d;

  assign tick = gate && (count_q == div);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (gate) begin
      count_d = tick ? '0 : count_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/machine_timer.sv
// ----------------------------------------------------------------------------
// machine_timer : memory-mapped mtime/mtimecmp with registered timeout level
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int          PRESCALE_W = 8,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable_design,
  machine_timer_if.slave        bus,
  output logic                  timer_timeout
);

  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           cmp_q, cmp_d;
  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [0:0]            state_q, state_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  timeout_q, timeout_d;

  logic                  tick;
  logic                  accept;
  logic                  wr;
  reg_sel_e              sel;
  logic [XLEN-1:0]       ctrl_val;
  logic [XLEN-1:0]       read_val;

  assign sel    = decode_addr(bus.bus_addr);
  assign accept = (state_q == BUS_IDLE) && bus.bus_req;
  assign wr     = accept && bus.bus_we && (sel != REG_NONE);

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .gate    (enable_design && en_q),
    .div     (div_q),
    .clear   (wr && (sel == REG_CTRL)),
    .tick    (tick)
  );

  always_comb begin
    ctrl_val                              = '0;
    ctrl_val[CTRL_EN_BIT]                 = en_q;
    ctrl_val[CTRL_DIV_LSB +: PRESCALE_W]  = div_q;
  end

  // Reads see the pre-edge registers, so a coincident tick is not visible yet.
  always_comb begin
    read_val = '0;
    case (sel)
      REG_MTIME_LO: read_val = mtime_q[31:0];
      REG_MTIME_HI: read_val = mtime_q[63:32];
      REG_CMP_LO:   read_val = cmp_q[31:0];
      REG_CMP_HI:   read_val = cmp_q[63:32];
      REG_CTRL:     read_val = ctrl_val;
      default:      read_val = '0;
    endcase
  end

  // A bus write to either mtime half replaces that half and drops the tick.
  always_comb begin
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    div_d   = div_q;
    if (wr) begin
      case (sel)
        REG_MTIME_LO: mtime_d = {mtime_q[63:32], bus.bus_wdata};
        REG_MTIME_HI: mtime_d = {bus.bus_wdata, mtime_q[31:0]};
        REG_CMP_LO:   cmp_d   = {cmp_q[63:32], bus.bus_wdata};
        REG_CMP_HI:   cmp_d   = {bus.bus_wdata, cmp_q[31:0]};
        REG_CTRL: begin
          en_d  = bus.bus_wdata[CTRL_EN_BIT];
          div_d = bus.bus_wdata[CTRL_DIV_LSB +: PRESCALE_W];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    timeout_d = en_q && (mtime_q >= cmp_q);
    rdata_d   = rdata_q;
    err_d     = err_q;
    if (accept) begin
      err_d   = (sel == REG_NONE);
      rdata_d = (!bus.bus_we && (sel != REG_NONE)) ? read_val : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mtime_q   <= '0;
      cmp_q     <= CMP_RESET;
      en_q      <= 1'b1;
      div_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      mtime_q   <= mtime_d;
      cmp_q     <= cmp_d;
      en_q      <= en_d;
      div_q     <= div_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign timer_timeout = timeout_q;

  // Bus handshake FSM: state register, next state, outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BUS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUS_IDLE: if (bus.bus_req) state_d = BUS_RESP;
      BUS_RESP: state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    bus.bus_ack   = (state_q == BUS_RESP);
    bus.bus_err   = (state_q == BUS_RESP) && err_q;
    bus.bus_rdata = (state_q == BUS_RESP) ? rdata_q : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_machine_timer.sv
// ----------------------------------------------------------------------------
// tb_machine_timer : directed scenarios plus random register traffic against a
// cycle model of the timer's architectural state.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_machine_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable_design;
  logic        timer_timeout;
  logic        chk_on = 1'b0;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  machine_timer_if bus();

  machine_timer #(
    .PRESCALE_W (8),
    .CMP_RESET  (64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable_design (enable_design),
    .bus           (bus),
    .timer_timeout (timer_timeout)
  );

  always #5 clk = ~clk;

  // Architectural model: counter value, compare value, CTRL fields, number of
  // gated cycles elapsed in the current prescale period, and the pending reply.
  logic [63:0] m_mtime, m_cmp;
  logic        m_en;
  logic [7:0]  m_div;
  int unsigned m_phase;
  logic        m_to, m_pend, m_perr;
  logic [31:0] m_prd;

  task automatic model_reset();
    m_mtime = 64'd0;
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    m_en    = 1'b1;
    m_div   = 8'd0;
    m_phase = 0;
    m_to    = 1'b0;
    m_pend  = 1'b0;
    m_perr  = 1'b0;
    m_prd   = 32'd0;
  endtask

  task automatic model_step();
    bit          gated, tick, acc, ok, to_next;
    logic [31:0] rv;
    logic [63:0] nxt;
    gated   = enable_design && m_en;
    tick    = gated && (m_phase == int'(m_div));
    to_next = m_en && (m_mtime >= m_cmp);
    acc     = !m_pend && bus.bus_req;
    ok      = (bus.bus_addr < 5'h14) && (bus.bus_addr[1:0] == 2'b00);
    case (bus.bus_addr)
      5'h00:   rv = m_mtime[31:0];
      5'h04:   rv = m_mtime[63:32];
      5'h08:   rv = m_cmp[31:0];
      5'h0C:   rv = m_cmp[63:32];
      5'h10:   rv = {16'h0, m_div, 7'h0, m_en};
      default: rv = 32'h0;
    endcase
    if (gated) m_phase = tick ? 0 : m_phase + 1;
    nxt = m_mtime + (tick ? 64'd1 : 64'd0);
    if (acc && ok && bus.bus_we) begin
      case (bus.bus_addr)
        5'h00: nxt = {m_mtime[63:32], bus.bus_wdata};
        5'h04: nxt = {bus.bus_wdata, m_mtime[31:0]};
        5'h08: m_cmp = {m_cmp[63:32], bus.bus_wdata};
        5'h0C: m_cmp = {bus.bus_wdata, m_cmp[31:0]};
        5'h10: begin
          m_en    = bus.bus_wdata[0];
          m_div   = bus.bus_wdata[15:8];
          m_phase = 0;
        end
        default: ;
      endcase
    end
    m_mtime = nxt;
    m_to    = to_next;
    m_perr  = acc && !ok;
    m_prd   = (acc && ok && !bus.bus_we) ? rv : 32'h0;
    m_pend  = acc;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ack", 64'(bus.bus_ack), 64'(m_pend));
      chk("err", 64'(bus.bus_err), 64'(m_pend && m_perr));
      chk("timeout", 64'(timer_timeout), 64'(m_to));
      if (m_pend) chk("rdata", 64'(bus.bus_rdata), 64'(m_prd));
    end
  end

  task automatic bus_xfer(input logic we, input logic [4:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er);
    bit got;
    @(negedge clk);
    bus.bus_req   = 1'b1;
    bus.bus_we    = we;
    bus.bus_addr  = a;
    bus.bus_wdata = d;
    @(posedge clk);
    #1;
    bus.bus_req = 1'b0;
    got = 0;
    rd  = 32'h0;
    er  = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (bus.bus_ack) begin
        got = 1;
        rd  = bus.bus_rdata;
        er  = bus.bus_err;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_wait: no bus_ack within 4 cycles, required 1 (addr %h)", a);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, v1, v2, v3;
    logic        er;
    logic [4:0]  a;
    logic [31:0] d;
    logic        w;

    reset_n           = 1'b0;
    enable_design     = 1'b1;
    bus.bus_req       = 1'b0;
    bus.bus_we        = 1'b0;
    bus.bus_addr      = 5'h0;
    bus.bus_wdata     = 32'h0;
    #1 chk_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_timeout", 64'(timer_timeout), 64'd0);
    chk("reset_ack", 64'(bus.bus_ack), 64'd0);
    reset_n = 1'b1;

    // 1: ten ticks at DIV=0
    repeat (10) @(posedge clk);
    bus_xfer(1'b0, 5'h00, 32'h0, rd, er);
    chk("t1_mtime_lo", 64'(rd), 64'd10);
    chk("t1_err", 64'(er), 64'd0);
    chk("t1_timeout", 64'(timer_timeout), 64'd0);

    // 2: compare at 20, then move it away
    bus_xfer(1'b1, 5'h0C, 32'h0, rd, er);
    bus_xfer(1'b1, 5'h08, 32'd20, rd, er);
    repeat (5) @(negedge clk);
    chk("t2_before", 64'(timer_timeout), 64'd0);
    @(negedge clk);
    chk("t2_rise", 64'(timer_timeout), 64'd1);
    bus_xfer(1'b1, 5'h08, 32'd100, rd, er);
    chk("t2_hold", 64'(timer_timeout), 64'd1);
    @(negedge clk);
    chk("t2_fall", 64'(timer_timeout), 64'd0);

    // 3: DIV=3, with a freeze window that must preserve phase
    bus_xfer(1'b1, 5'h10, 32'h0000_0301, rd, er);
    bus_xfer(1'b0, 5'h00, 32'h0, v1, er);
    repeat (16) @(negedge clk);
    bus_xfer(1'b0, 5'h00, 32'h0, v2, er);
    chk("t3_div4_rate", 64'(v2 - v1), 64'd4);
    enable_design = 1'b0;
    repeat (7) @(negedge clk);
    enable_design = 1'b1;
    repeat (8) @(negedge clk);
    bus_xfer(1'b0, 5'h00, 32'h0, v3, er);
    chk("t3_freeze_phase", 64'(v3 - v2), 64'd3);
    bus_xfer(1'b0, 5'h10, 32'h0, rd, er);
    chk("t3_ctrl", 64'(rd), 64'h301);
    bus_xfer(1'b1, 5'h10, 32'h0000_0001, rd, er);

    // 4: all-ones wrap
    enable_design = 1'b0;
    bus_xfer(1'b1, 5'h0C, 32'hFFFF_FFFF, rd, er);
    bus_xfer(1'b1, 5'h08, 32'hFFFF_FFFF, rd, er);
    bus_xfer(1'b1, 5'h00, 32'hFFFF_FFFF, rd, er);
    bus_xfer(1'b1, 5'h04, 32'hFFFF_FFFF, rd, er);
    @(negedge clk);
    chk("t4_max_timeout", 64'(timer_timeout), 64'd1);
    enable_design = 1'b1;
    @(negedge clk);
    enable_design = 1'b0;
    chk("t4_wrap_lag", 64'(timer_timeout), 64'd1);
    @(negedge clk);
    chk("t4_wrap_drop", 64'(timer_timeout), 64'd0);
    bus_xfer(1'b0, 5'h00, 32'h0, rd, er);
    chk("t4_lo_zero", 64'(rd), 64'd0);
    bus_xfer(1'b0, 5'h04, 32'h0, rd, er);
    chk("t4_hi_zero", 64'(rd), 64'd0);

    // 5: write/tick collision and error responses
    enable_design = 1'b1;
    bus_xfer(1'b1, 5'h00, 32'h55, rd, er);
    bus_xfer(1'b0, 5'h00, 32'h0, rd, er);
    chk("t5_write_wins", 64'(rd), 64'h56);
    enable_design = 1'b0;
    bus_xfer(1'b1, 5'h14, 32'hDEAD_BEEF, rd, er);
    chk("t5_unmapped_err", 64'(er), 64'd1);
    chk("t5_unmapped_rdata", 64'(rd), 64'd0);
    bus_xfer(1'b0, 5'h06, 32'h0, rd, er);
    chk("t5_misaligned_err", 64'(er), 64'd1);
    bus_xfer(1'b0, 5'h10, 32'h0, rd, er);
    chk("t5_ctrl_intact", 64'(rd), 64'h1);
    chk("t5_ctrl_err", 64'(er), 64'd0);

    // Random register traffic with enable_design toggling
    for (int n = 0; n < 400; n++) begin
      enable_design = ($urandom_range(0, 7) != 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 3) != 0) a = 5'(4 * $urandom_range(0, 4));
      else                           a = 5'($urandom_range(0, 31));
      w = 1'($urandom_range(0, 1));
      case (a)
        5'h10:        d = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 3)) << 8)
                          | 32'($urandom_range(0, 5) != 0);
        5'h04, 5'h0C: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
        default:      d = 32'($urandom_range(0, 300));
      endcase
      bus_xfer(w, a, d, rd, er);
    end

    // 6: asynchronous reset in the middle of a response with timeout high
    enable_design = 1'b0;
    bus_xfer(1'b1, 5'h10, 32'h0000_0001, rd, er);
    bus_xfer(1'b1, 5'h0C, 32'h0, rd, er);
    bus_xfer(1'b1, 5'h08, 32'h0, rd, er);
    repeat (2) @(negedge clk);
    chk("t6_timeout_high", 64'(timer_timeout), 64'd1);
    @(negedge clk);
    bus.bus_req  = 1'b1;
    bus.bus_we   = 1'b0;
    bus.bus_addr = 5'h08;
    @(posedge clk);
    #1 bus.bus_req = 1'b0;
    chk("t6_in_resp", 64'(bus.bus_ack), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_reset_ack", 64'(bus.bus_ack), 64'd0);
    chk("t6_reset_timeout", 64'(timer_timeout), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_xfer(1'b0, 5'h08, 32'h0, rd, er);
    chk("t6_cmp_lo", 64'(rd), 64'hFFFF_FFFF);
    bus_xfer(1'b0, 5'h0C, 32'h0, rd, er);
    chk("t6_cmp_hi", 64'(rd), 64'hFFFF_FFFF);
    bus_xfer(1'b0, 5'h00, 32'h0, rd, er);
    chk("t6_mtime_zero", 64'(rd), 64'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
